// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch stage with 2-entry output buffer and redirect
//
// Purpose:
//   Keeps a 32-bit fetch PC and issues word reads to a synchronous instruction
//   memory. Returned words are paired with their PC and buffered in a 2-entry
//   FIFO that feeds decode through a valid/ready handshake. A redirect flushes
//   the buffer, drops the in-flight response and restarts fetch at the new PC.
//
// Ports:
//   clk              in   clock, all state on rising edge
//   rst              in   synchronous active-high reset
//   imem_rd_en       out  read strobe to instruction memory
//   imem_rd_addr     out  word address (pc[AW+1:2])
//   imem_instruction in   read data, valid the cycle after imem_rd_en
//   out_valid        out  head entry available to decode
//   out_ready        in   decode accepts head entry
//   out_instr        out  head instruction word
//   out_pc           out  head byte address
//   redirect_valid   in   branch/jump redirect request
//   redirect_pc      in   new byte fetch address

module instruction_fetch #(
  parameter int          INST_WIDTH = 32,
  parameter int          INST_DEPTH = 16,
  parameter logic [31:0] RESET_PC   = 32'h0,
  localparam int         AW         = $clog2(INST_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_rd_en,
  output logic [AW-1:0]         imem_rd_addr,
  input  logic [INST_WIDTH-1:0] imem_instruction,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_WIDTH-1:0] out_instr,
  output logic [31:0]           out_pc,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc
);

  logic [31:0]           pc;
  logic [31:0]           inflight_pc;
  logic                  inflight;
  logic [1:0]            count;
  logic [INST_WIDTH-1:0] e0_instr, e1_instr;
  logic [31:0]           e0_pc, e1_pc;
  logic                  pop, push;
  logic [2:0]            level;
  logic [1:0]            push_slot;
  logic [31:0]           redirect_aligned;

  assign out_valid    = (count != 2'd0);
  assign out_instr    = e0_instr;
  assign out_pc       = e0_pc;
  assign pop          = out_valid && out_ready;

  // Entries that will occupy the buffer after this edge if nothing new is
  // issued; issuing only when this is below 2 makes overflow impossible.
  assign level        = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign imem_rd_en   = !rst && !redirect_valid && (level < 3'd2);
  assign imem_rd_addr = pc[AW+1:2];

  // A response returning in a redirect cycle belongs to the old path.
  assign push         = inflight && !redirect_valid;
  assign push_slot    = count - {1'b0, pop};

  assign redirect_aligned = redirect_pc & ~32'd3;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      count       <= 2'd0;
      e0_instr    <= '0;
      e1_instr    <= '0;
      e0_pc       <= 32'h0;
      e1_pc       <= 32'h0;
    end else begin
      inflight <= imem_rd_en;
      if (imem_rd_en) begin
        inflight_pc <= pc;
        pc          <= pc + 32'd4;
      end

      if (redirect_valid) begin
        // Any same-cycle transfer has already been consumed by decode.
        pc    <= redirect_aligned;
        count <= 2'd0;
      end else begin
        count <= count + {1'b0, push} - {1'b0, pop};

        if (pop && (count == 2'd2)) begin
          e0_instr <= e1_instr;
          e0_pc    <= e1_pc;
        end

        // push_slot is 0 or 1 here; the issue throttle keeps it below 2.
        if (push) begin
          if (push_slot == 2'd0) begin
            e0_instr <= imem_instruction;
            e0_pc    <= inflight_pc;
          end else begin
            e1_instr <= imem_instruction;
            e1_pc    <= inflight_pc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - testbench for instruction_fetch

module tb_instruction_fetch;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_rd_en;
  logic [AW-1:0] imem_rd_addr;
  logic [31:0]   imem_instruction;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;

  instruction_fetch #(
    .INST_WIDTH(32),
    .INST_DEPTH(16),
    .RESET_PC  (32'h0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_rd_en      (imem_rd_en),
    .imem_rd_addr    (imem_rd_addr),
    .imem_instruction(imem_instruction),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  always #5 clk = ~clk;

  // Memory word k holds 32'h1000 + k, one-cycle read latency.
  initial imem_instruction = 32'h0;
  always @(posedge clk) begin
    if (imem_rd_en) imem_instruction <= 32'h1000 + {28'h0, imem_rd_addr};
  end

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        en;
    logic [3:0]  addr;
    logic        chk_out;
    logic        ov;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_xfer   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                     input logic en, input logic [3:0] addr, input logic co,
                     input logic ov, input logic [31:0] pc, input logic [31:0] instr);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.en = en; v.addr = addr;
    v.chk_out = co; v.ov = ov; v.pc = pc; v.instr = instr;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst            = r;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  // Scoreboard: transfers are checked against the expected PC stream; a reset
  // or redirect replaces the stream starting at its target address.
  task automatic sb_sample();
    logic [31:0] e;
    logic [31:0] base;
    if (!rst && out_valid && out_ready) begin
      n_xfer++;
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_xfer", out_pc, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", out_pc, e);
        chk("sb_instr", out_instr, 32'h1000 + {28'h0, e[5:2]});
      end
    end
    if (rst || redirect_valid) begin
      base = rst ? 32'h0 : (redirect_pc & ~32'd3);
      exp_q.delete();
      for (int i = 0; i < 16; i++) exp_q.push_back(base + 32'(4 * i));
    end
  endtask

  initial begin
    rst            = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    //  rst rdy rv rpc       en addr chk ov pc        instr
    // streaming from reset
    add(0, 1, 0, 32'h0,  1, 0,  1, 0, 32'h0,  32'h0);
    add(0, 1, 0, 32'h0,  1, 1,  1, 0, 32'h0,  32'h0);
    add(0, 1, 0, 32'h0,  1, 2,  1, 1, 32'h0,  32'h1000);
    add(0, 1, 0, 32'h0,  1, 3,  1, 1, 32'h4,  32'h1001);
    add(0, 1, 0, 32'h0,  1, 4,  1, 1, 32'h8,  32'h1002);
    add(0, 1, 0, 32'h0,  1, 5,  1, 1, 32'hC,  32'h1003);
    // one-cycle reset mid-stream, then stall with decode not ready
    add(1, 0, 0, 32'h0,  0, 0,  0, 0, 32'h0,  32'h0);
    add(0, 0, 0, 32'h0,  1, 0,  1, 0, 32'h0,  32'h0);
    add(0, 0, 0, 32'h0,  1, 1,  1, 0, 32'h0,  32'h0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 32'h0, 0, 0, 1, 1, 32'h0, 32'h1000);
    add(0, 1, 0, 32'h0,  1, 2,  1, 1, 32'h0,  32'h1000);
    add(0, 1, 0, 32'h0,  1, 3,  1, 1, 32'h4,  32'h1001);
    add(0, 1, 0, 32'h0,  1, 4,  1, 1, 32'h8,  32'h1002);
    // fill the buffer, then redirect to 0x20
    add(0, 0, 0, 32'h0,  0, 0,  1, 1, 32'hC,  32'h1003);
    add(0, 0, 1, 32'h20, 0, 0,  1, 1, 32'hC,  32'h1003);
    add(0, 1, 0, 32'h0,  1, 8,  1, 0, 32'h0,  32'h0);
    add(0, 1, 0, 32'h0,  1, 9,  1, 0, 32'h0,  32'h0);
    add(0, 1, 0, 32'h0,  1, 10, 1, 1, 32'h20, 32'h1008);
    // redirect coincident with transfer and an in-flight read; unaligned target
    add(0, 1, 1, 32'h3E, 0, 0,  1, 1, 32'h24, 32'h1009);
    add(0, 1, 0, 32'h0,  1, 15, 1, 0, 32'h0,  32'h0);
    add(0, 1, 0, 32'h0,  1, 0,  1, 0, 32'h0,  32'h0);
    add(0, 1, 0, 32'h0,  1, 1,  1, 1, 32'h3C, 32'h100F);
    add(0, 1, 0, 32'h0,  1, 2,  1, 1, 32'h40, 32'h1000);
    add(0, 1, 0, 32'h0,  1, 3,  1, 1, 32'h44, 32'h1001);
    // back-to-back redirects: the last one wins
    add(0, 1, 1, 32'h10, 0, 0,  1, 1, 32'h48, 32'h1002);
    add(0, 1, 1, 32'h30, 0, 0,  1, 0, 32'h0,  32'h0);
    add(0, 1, 0, 32'h0,  1, 12, 1, 0, 32'h0,  32'h0);
    add(0, 1, 0, 32'h0,  1, 13, 1, 0, 32'h0,  32'h0);
    add(0, 1, 0, 32'h0,  1, 14, 1, 1, 32'h30, 32'h100C);
    add(0, 1, 0, 32'h0,  1, 15, 1, 1, 32'h34, 32'h100D);

    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 32'h0);
      @(negedge clk);
      sb_sample();
    end
    chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset_rd_en", {31'h0, imem_rd_en}, 32'h0);
    chk("reset_out_pc", out_pc, 32'h0);
    chk("reset_out_instr", out_instr, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
      @(negedge clk);
      chk($sformatf("v%0d_rd_en", i), {31'h0, imem_rd_en}, {31'h0, vecs[i].en});
      if (vecs[i].en)
        chk($sformatf("v%0d_rd_addr", i), {28'h0, imem_rd_addr}, {28'h0, vecs[i].addr});
      if (vecs[i].chk_out) begin
        chk($sformatf("v%0d_out_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].ov});
        if (vecs[i].ov) begin
          chk($sformatf("v%0d_out_pc", i), out_pc, vecs[i].pc);
          chk($sformatf("v%0d_out_instr", i), out_instr, vecs[i].instr);
        end
      end
      sb_sample();
    end

    // Reset overriding a redirect and a transfer mid-stream.
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 32'h0);
      @(negedge clk);
      sb_sample();
    end
    drive(1, 1, 1, 32'h20);
    @(negedge clk);
    chk("rst_ovr_rd_en", {31'h0, imem_rd_en}, 32'h0);
    sb_sample();
    drive(0, 1, 0, 32'h0);
    @(negedge clk);
    chk("post_rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("post_rst_rd_en", {31'h0, imem_rd_en}, 32'h1);
    chk("post_rst_rd_addr", {28'h0, imem_rd_addr}, 32'h0);
    chk("post_rst_out_pc", out_pc, 32'h0);
    chk("post_rst_out_instr", out_instr, 32'h0);
    sb_sample();
    drive(0, 1, 0, 32'h0);
    @(negedge clk);
    chk("post_rst_c1_out_valid", {31'h0, out_valid}, 32'h0);
    sb_sample();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 32'h0);
      @(negedge clk);
      chk($sformatf("post_rst_c%0d_out_valid", i + 2), {31'h0, out_valid}, 32'h1);
      sb_sample();
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 32'h0);
      @(negedge clk);
      sb_sample();
    end

    chk("xfer_count", n_xfer, 32'd19);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
